execute_cycle: RTL and testbench



---
 rtl/execute_cycle_pkg.sv | 46 ++++
 rtl/execute_cycle_if.sv | 63 ++++++
 rtl/execute_cycle_alu.sv | 42 ++++
 rtl/execute_cycle.sv | 86 ++++++++
 tb/tb_execute_cycle.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/execute_cycle_pkg.sv
`default_nettype none
// ============================================================================
// Module   : execute_cycle_pkg
// Purpose  : Shared pipeline definitions for the execute stage.
//            Holds the ALU operation encoding, the forward-select encoding,
//            and a helper that implements one forwarding mux.
// Revision : 1.0 - initial release
// ============================================================================
package execute_cycle_pkg;

  localparam int PIPE_XLEN = 32;

  typedef logic [2:0] aluCtrl_t;
  typedef logic [1:0] fwdSel_t;

  // ALU operation encoding (100, 110, 111 are unused and produce zero)
  localparam aluCtrl_t ALU_ADD = 3'b000;
  localparam aluCtrl_t ALU_SUB = 3'b001;
  localparam aluCtrl_t ALU_AND = 3'b010;
  localparam aluCtrl_t ALU_OR  = 3'b011;
  localparam aluCtrl_t ALU_SLT = 3'b101;

  // Forward-select encoding from the hazard unit
  localparam fwdSel_t FWD_REG = 2'b00;
  localparam fwdSel_t FWD_WB  = 2'b01;
  localparam fwdSel_t FWD_MEM = 2'b10;

  // One operand forwarding mux; the spare code 11 falls back to the
  // register-file value so a hazard-unit glitch never injects garbage.
  function automatic logic [PIPE_XLEN-1:0] fwdSelect(
    input fwdSel_t               sel,
    input logic [PIPE_XLEN-1:0] regVal,
    input logic [PIPE_XLEN-1:0] wbVal,
    input logic [PIPE_XLEN-1:0] memVal
  );
    logic [PIPE_XLEN-1:0] val;
    case (sel)
      FWD_WB:  val = wbVal;
      FWD_MEM: val = memVal;
      default: val = regVal;
    endcase
    return val;
  endfunction

endpackage : execute_cycle_pkg
`default_nettype wire

// File: rtl/execute_cycle_if.sv
`default_nettype none
// ============================================================================
// Module   : execute_cycle_if
// Purpose  : ID/EX input bundle, hazard-unit forward selects, branch feedback
//            to fetch and the EX/MEM output bundle of the execute stage.
// Modports : master - upstream side (drives ID/EX, reads EX/MEM and branch)
//            slave  - the execute stage itself
// Revision : 1.0 - initial release
// ============================================================================
interface execute_cycle_if #(
  parameter int XLEN = 32
);

  // ID/EX control
  logic            RegWriteE;
  logic            ALUSrcE;
  logic            MemWriteE;
  logic            ResultSrcE;
  logic            BranchE;
  logic [2:0]      ALUControlE;
  // ID/EX operands
  logic [XLEN-1:0] RD1_E;
  logic [XLEN-1:0] RD2_E;
  logic [XLEN-1:0] Imm_Ext_E;
  logic [XLEN-1:0] PCE;
  logic [XLEN-1:0] PCPlus4E;
  logic [4:0]      RD_E;
  // Forwarding
  logic [1:0]      ForwardAE;
  logic [1:0]      ForwardBE;
  logic [XLEN-1:0] ResultW;
  // Branch resolution back to fetch
  logic            PCSrcE;
  logic [XLEN-1:0] PCTargetE;
  // EX/MEM bundle
  logic            RegWriteM;
  logic            MemWriteM;
  logic            ResultSrcM;
  logic [4:0]      RD_M;
  logic [XLEN-1:0] ALUResultM;
  logic [XLEN-1:0] WriteDataM;
  logic [XLEN-1:0] PCPlus4M;

  modport master (
    output RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
           RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E,
           ForwardAE, ForwardBE, ResultW,
    input  PCSrcE, PCTargetE,
           RegWriteM, MemWriteM, ResultSrcM, RD_M,
           ALUResultM, WriteDataM, PCPlus4M
  );

  modport slave (
    input  RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
           RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E,
           ForwardAE, ForwardBE, ResultW,
    output PCSrcE, PCTargetE,
           RegWriteM, MemWriteM, ResultSrcM, RD_M,
           ALUResultM, WriteDataM, PCPlus4M
  );

endinterface : execute_cycle_if
`default_nettype wire

// File: rtl/execute_cycle_alu.sv
`default_nettype none
// ============================================================================
// Module   : alu
// Purpose  : Combinational RV32I ALU (add, sub, and, or, signed slt).
// Ports    : SrcA, SrcB   - operands
//            ALUControl   - operation select
//            Result       - operation result (zero for unused encodings)
//            Zero         - Result == 0
// Revision : 1.0 - initial release
// ============================================================================
module alu
  import execute_cycle_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  aluCtrl_t         ALUControl,
  output logic [WIDTH-1:0] Result,
  output logic             Zero
);

  logic w_lessThan;

  assign w_lessThan = ($signed(SrcA) < $signed(SrcB));

  always_comb begin
    Result = '0;
    case (ALUControl)
      ALU_ADD: Result = SrcA + SrcB;   // wraps, overflow ignored
      ALU_SUB: Result = SrcA - SrcB;
      ALU_AND: Result = SrcA & SrcB;
      ALU_OR:  Result = SrcA | SrcB;
      ALU_SLT: Result = {{(WIDTH-1){1'b0}}, w_lessThan};
      default: Result = '0;
    endcase
  end

  assign Zero = (Result == '0);

endmodule : alu
`default_nettype wire

// File: rtl/execute_cycle.sv
`default_nettype none
// ============================================================================
// Module   : execute_cycle
// Purpose  : Execute stage of the five-stage RV32I pipeline. Applies operand
//            forwarding, runs the ALU, resolves BEQ back to fetch and
//            registers the EX/MEM bundle.
// Ports    : clk - pipeline clock
//            rst - synchronous active-high reset of the EX/MEM register
//            ex  - execute_cycle_if.slave (ID/EX in, branch + EX/MEM out)
// Revision : 1.0 - initial release
// ============================================================================
module execute_cycle
  import execute_cycle_pkg::*;
#(
  parameter int XLEN = 32   // only 32 is supported
) (
  input  logic             clk,
  input  logic             rst,
  execute_cycle_if.slave   ex
);

  logic [XLEN-1:0] w_srcA;
  logic [XLEN-1:0] w_fwdB;
  logic [XLEN-1:0] w_srcB;
  logic [XLEN-1:0] w_aluResult;
  logic            w_zero;

  logic            r_regWriteM;
  logic            r_memWriteM;
  logic            r_resultSrcM;
  logic [4:0]      r_rdM;
  logic [XLEN-1:0] r_aluResultM;
  logic [XLEN-1:0] r_writeDataM;
  logic [XLEN-1:0] r_pcPlus4M;

  // FWD_MEM feeds back this stage's own registered result, i.e. the
  // previous instruction's ALU output.
  assign w_srcA = fwdSelect(ex.ForwardAE, ex.RD1_E, ex.ResultW, r_aluResultM);
  assign w_fwdB = fwdSelect(ex.ForwardBE, ex.RD2_E, ex.ResultW, r_aluResultM);
  assign w_srcB = ex.ALUSrcE ? ex.Imm_Ext_E : w_fwdB;

  alu #(
    .WIDTH (XLEN)
  ) u_alu (
    .SrcA       (w_srcA),
    .SrcB       (w_srcB),
    .ALUControl (ex.ALUControlE),
    .Result     (w_aluResult),
    .Zero       (w_zero)
  );

  // Branch resolution stays combinational, including while rst is high.
  assign ex.PCSrcE    = ex.BranchE & w_zero;
  assign ex.PCTargetE = ex.PCE + ex.Imm_Ext_E;

  // EX/MEM register: loads every edge; bubbles arrive as zeroed control.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_regWriteM  <= 1'b0;
      r_memWriteM  <= 1'b0;
      r_resultSrcM <= 1'b0;
      r_rdM        <= 5'h00;
      r_aluResultM <= '0;
      r_writeDataM <= '0;
      r_pcPlus4M   <= '0;
    end else begin
      r_regWriteM  <= ex.RegWriteE;
      r_memWriteM  <= ex.MemWriteE;
      r_resultSrcM <= ex.ResultSrcE;
      r_rdM        <= ex.RD_E;
      r_aluResultM <= w_aluResult;
      r_writeDataM <= w_fwdB;          // store data ignores the immediate mux
      r_pcPlus4M   <= ex.PCPlus4E;
    end
  end

  assign ex.RegWriteM  = r_regWriteM;
  assign ex.MemWriteM  = r_memWriteM;
  assign ex.ResultSrcM = r_resultSrcM;
  assign ex.RD_M       = r_rdM;
  assign ex.ALUResultM = r_aluResultM;
  assign ex.WriteDataM = r_writeDataM;
  assign ex.PCPlus4M   = r_pcPlus4M;

endmodule : execute_cycle
`default_nettype wire

// File: tb/tb_execute_cycle.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_cycle
// Purpose  : Self-checking bench for execute_cycle: directed vector table
//            plus reset-in-flight sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_execute_cycle;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  execute_cycle_if #(.XLEN(32)) exIf ();

  execute_cycle #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .ex  (exIf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic        aluSrc;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] resultW;
    logic        regW;
    logic        memW;
    logic        resSrc;
    logic        branch;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic [31:0] expAlu;
    logic [31:0] expWd;
    logic        expPcSrc;
    logic [31:0] expTarget;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  function automatic vec_t mk(
    input logic [2:0] op, input logic aluSrc, input logic [1:0] fa, input logic [1:0] fb,
    input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm, input logic [31:0] resultW,
    input logic regW, input logic memW, input logic resSrc, input logic branch,
    input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] pcPlus4,
    input logic [31:0] expAlu, input logic [31:0] expWd, input logic expPcSrc, input logic [31:0] expTarget
  );
    vec_t v;
    v.op = op; v.aluSrc = aluSrc; v.fa = fa; v.fb = fb;
    v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.resultW = resultW;
    v.regW = regW; v.memW = memW; v.resSrc = resSrc; v.branch = branch;
    v.rd = rd; v.pc = pc; v.pcPlus4 = pcPlus4;
    v.expAlu = expAlu; v.expWd = expWd; v.expPcSrc = expPcSrc; v.expTarget = expTarget;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    exIf.ALUControlE = v.op;
    exIf.ALUSrcE     = v.aluSrc;
    exIf.ForwardAE   = v.fa;
    exIf.ForwardBE   = v.fb;
    exIf.RD1_E       = v.rd1;
    exIf.RD2_E       = v.rd2;
    exIf.Imm_Ext_E   = v.imm;
    exIf.ResultW     = v.resultW;
    exIf.RegWriteE   = v.regW;
    exIf.MemWriteE   = v.memW;
    exIf.ResultSrcE  = v.resSrc;
    exIf.BranchE     = v.branch;
    exIf.RD_E        = v.rd;
    exIf.PCE         = v.pc;
    exIf.PCPlus4E    = v.pcPlus4;
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, ".RegWriteM"},  {31'd0, exIf.RegWriteM},  32'h0);
    check({tag, ".MemWriteM"},  {31'd0, exIf.MemWriteM},  32'h0);
    check({tag, ".ResultSrcM"}, {31'd0, exIf.ResultSrcM}, 32'h0);
    check({tag, ".RD_M"},       {27'd0, exIf.RD_M},       32'h0);
    check({tag, ".ALUResultM"}, exIf.ALUResultM,          32'h0);
    check({tag, ".WriteDataM"}, exIf.WriteDataM,          32'h0);
    check({tag, ".PCPlus4M"},   exIf.PCPlus4M,            32'h0);
  endtask

  initial begin
    vec_t v;
    total = 0;
    bad   = 0;

    //              op  src fa fb rd1           rd2           imm           resultW       rW mW rS br rd  pc         pc+4       expAlu        expWd         pcS target
    vecs[0]  = mk(3'd0, 0, 0, 0, 32'd5,        32'd7,        32'd0,        32'd0,        1, 0, 0, 0, 3,  32'h0,     32'h4,     32'd12,       32'd7,        0, 32'h0);
    vecs[1]  = mk(3'd0, 1, 1, 0, 32'd1,        32'd55,       32'd4,        32'd100,      1, 0, 0, 0, 5,  32'h200,   32'h204,   32'd104,      32'd55,       0, 32'h204);
    vecs[2]  = mk(3'd0, 0, 0, 2, 32'd0,        32'd9,        32'd8,        32'd0,        1, 0, 0, 0, 6,  32'h10,    32'h14,    32'd104,      32'd104,      0, 32'h18);
    vecs[3]  = mk(3'd5, 0, 0, 0, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,        1, 0, 0, 0, 7,  32'h20,    32'h24,    32'd1,        32'd1,        0, 32'h20);
    vecs[4]  = mk(3'd5, 0, 0, 0, 32'd1,        32'hFFFFFFFF, 32'd0,        32'd0,        1, 0, 0, 0, 8,  32'h24,    32'h28,    32'd0,        32'hFFFFFFFF, 0, 32'h24);
    vecs[5]  = mk(3'd1, 0, 0, 0, 32'd9,        32'd9,        32'hFFFFFFF0, 32'd0,        0, 0, 0, 1, 0,  32'h100,   32'h104,   32'd0,        32'd9,        1, 32'hF0);
    vecs[6]  = mk(3'd1, 0, 0, 0, 32'd9,        32'd4,        32'hFFFFFFF0, 32'd0,        0, 0, 0, 1, 0,  32'h100,   32'h104,   32'd5,        32'd4,        0, 32'hF0);
    vecs[7]  = mk(3'd0, 1, 0, 1, 32'h1000,     32'h11,       32'd8,        32'hDEADBEEF, 0, 1, 0, 0, 0,  32'h0,     32'h4,     32'h1008,     32'hDEADBEEF, 0, 32'h8);
    vecs[8]  = mk(3'd2, 0, 0, 0, 32'hF0F0,     32'hFF00,     32'd0,        32'd0,        1, 0, 1, 0, 9,  32'h0,     32'h4,     32'hF000,     32'hFF00,     0, 32'h0);
    vecs[9]  = mk(3'd3, 0, 0, 0, 32'hF0F0,     32'h0F0F,     32'd0,        32'd0,        1, 0, 0, 0, 10, 32'h0,     32'h4,     32'hFFFF,     32'h0F0F,     0, 32'h0);
    vecs[10] = mk(3'd0, 0, 3, 3, 32'd3,        32'd4,        32'd0,        32'd77,       1, 0, 0, 0, 11, 32'h0,     32'h4,     32'd7,        32'd4,        0, 32'h0);
    vecs[11] = mk(3'd4, 0, 0, 0, 32'd12,       32'd34,       32'h10,       32'd0,        0, 0, 0, 1, 0,  32'h40,    32'h44,    32'd0,        32'd34,       1, 32'h50);
    vecs[12] = mk(3'd6, 0, 0, 0, 32'd5,        32'd5,        32'd0,        32'd0,        1, 0, 0, 0, 12, 32'h0,     32'h4,     32'd0,        32'd5,        0, 32'h0);
    vecs[13] = mk(3'd7, 0, 0, 0, 32'd8,        32'd1,        32'h20,       32'd0,        0, 0, 0, 1, 0,  32'h80,    32'h84,    32'd0,        32'd1,        1, 32'hA0);
    vecs[14] = mk(3'd1, 0, 0, 0, 32'd0,        32'd1,        32'd0,        32'd0,        1, 0, 0, 0, 13, 32'h0,     32'h4,     32'hFFFFFFFF, 32'd1,        0, 32'h0);
    vecs[15] = mk(3'd0, 0, 0, 0, 32'hFFFFFFFF, 32'd2,        32'd0,        32'd0,        1, 0, 0, 0, 14, 32'h0,     32'h4,     32'd1,        32'd2,        0, 32'h0);
    vecs[16] = mk(3'd0, 0, 2, 0, 32'd999,      32'd5,        32'd0,        32'd0,        1, 0, 0, 0, 15, 32'h0,     32'h4,     32'd6,        32'd5,        0, 32'h0);
    vecs[17] = mk(3'd1, 0, 0, 1, 32'd2,        32'd3,        32'd0,        32'h28,       1, 0, 0, 0, 31, 32'h0,     32'h4,     32'hFFFFFFDA, 32'h28,       0, 32'h0);

    // Reset with busy, nonzero inputs: registers must still clear.
    rst = 1'b1;
    v = mk(3'd0, 0, 0, 0, 32'd11, 32'd22, 32'd4, 32'd5, 1, 1, 1, 0, 9, 32'h40, 32'h44, 0, 0, 0, 0);
    drive(v);
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");

    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d.PCSrcE", i),    {31'd0, exIf.PCSrcE}, {31'd0, vecs[i].expPcSrc});
      check($sformatf("v%0d.PCTargetE", i), exIf.PCTargetE,       vecs[i].expTarget);
      @(posedge clk);
      #1;
      check($sformatf("v%0d.ALUResultM", i), exIf.ALUResultM,          vecs[i].expAlu);
      check($sformatf("v%0d.WriteDataM", i), exIf.WriteDataM,          vecs[i].expWd);
      check($sformatf("v%0d.RD_M", i),       {27'd0, exIf.RD_M},       {27'd0, vecs[i].rd});
      check($sformatf("v%0d.RegWriteM", i),  {31'd0, exIf.RegWriteM},  {31'd0, vecs[i].regW});
      check($sformatf("v%0d.MemWriteM", i),  {31'd0, exIf.MemWriteM},  {31'd0, vecs[i].memW});
      check($sformatf("v%0d.ResultSrcM", i), {31'd0, exIf.ResultSrcM}, {31'd0, vecs[i].resSrc});
      check($sformatf("v%0d.PCPlus4M", i),   exIf.PCPlus4M,            vecs[i].pcPlus4);
    end

    // Reset mid-stream: the instruction in EX is discarded, branch path
    // stays live from inputs.
    @(negedge clk);
    v = mk(3'd0, 0, 0, 0, 32'd11, 32'd22, 32'h10, 32'd0, 1, 1, 1, 0, 4, 32'h300, 32'h304, 0, 0, 0, 0);
    drive(v);
    rst = 1'b1;
    #1;
    check("midrst.PCTargetE", exIf.PCTargetE, 32'h310);
    @(posedge clk);
    #1;
    checkAllZero("midrst");

    // First instruction after reset release is captured on the next edge.
    @(negedge clk);
    rst = 1'b0;
    v = mk(3'd0, 0, 0, 0, 32'd2, 32'd2, 32'd0, 32'd0, 1, 0, 0, 0, 2, 32'h4, 32'h8, 0, 0, 0, 0);
    drive(v);
    @(posedge clk);
    #1;
    check("post.ALUResultM", exIf.ALUResultM,         32'd4);
    check("post.RD_M",       {27'd0, exIf.RD_M},      32'd2);
    check("post.RegWriteM",  {31'd0, exIf.RegWriteM}, 32'd1);
    check("post.PCPlus4M",   exIf.PCPlus4M,           32'h8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_execute_cycle
`default_nettype wire
